// File: rtl/msi_request_capture.sv
// msi_request_capture
// Four-channel request capture and grant stage. Each asynchronous request
// line is synchronised, edge-detected and latched into a pending register.
// One pending channel at a time is presented as a 2-bit grant index, using
// the same priority order as the downstream encoder (channel 3 highest).
// The grant is held until the consumer acknowledges it. A repeated event on
// a channel that is still pending is recorded as a sticky overrun.

module msi_request_capture #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] REQ,
    input  logic [3:0] MASK,
    input  logic       ACK,
    input  logic       CLR,
    output logic [3:0] PEND,
    output logic       VALID,
    output logic [1:0] IDX,
    output logic       E,
    output logic [3:0] OVR
);

    localparam int unsigned CHAIN_W = SYNC_STAGES * 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;

    // Flattened synchroniser chain: stage 0 occupies the low nibble, the
    // last stage (the synchronised output) the high nibble.
    logic [CHAIN_W-1:0] chain_q;
    logic [3:0]         sync_out;
    logic [3:0]         hist_q;

    logic [3:0]         rise;
    logic [3:0]         capture;
    logic [3:0]         ack_clr;
    logic [3:0]         ovr_set;
    logic [3:0]         pend_q;
    logic [3:0]         pend_d;
    logic [3:0]         ovr_q;
    logic [3:0]         ovr_d;
    logic [1:0]         idx_q;
    logic [1:0]         prio_idx;
    logic               load_grant;
    logic               release_grant;

    // Fixed-priority pick of the highest pending channel (3 wins over 0).
    function automatic logic [1:0] pick_highest(input logic [3:0] vec);
        logic [1:0] r;
        r = 2'd0;
        if (vec[3]) begin
            r = 2'd3;
        end else if (vec[2]) begin
            r = 2'd2;
        end else if (vec[1]) begin
            r = 2'd1;
        end else begin
            r = 2'd0;
        end
        return r;
    endfunction

    // Synchroniser chain and history flop for every request line.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            chain_q <= '0;
            hist_q  <= '0;
        end else begin
            chain_q <= {chain_q[CHAIN_W-5:0], REQ};
            hist_q  <= sync_out;
        end
    end

    assign sync_out = chain_q[CHAIN_W-1 -: 4];

    // Edge detection, capture, acknowledge clear and overrun detection.
    // A new rise on the same edge as an acknowledge is a fresh event, so it
    // re-sets the pending bit and is not counted as an overrun.
    always_comb begin
        rise     = sync_out & ~hist_q;
        capture  = rise & MASK;
        ack_clr  = '0;
        if (release_grant) begin
            ack_clr = 4'b0001 << idx_q;
        end
        ovr_set  = capture & pend_q & ~ack_clr;
        pend_d   = (pend_q & ~ack_clr) | capture;
        ovr_d    = (CLR ? 4'b0000 : ovr_q) | ovr_set;
        prio_idx = pick_highest(pend_q);
    end

    // Pending and sticky overrun registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pend_q <= '0;
            ovr_q  <= '0;
        end else begin
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
        end
    end

    // Grant state register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: grant when something is pending, release on ACK.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (pend_q != 4'b0000) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (ACK) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State-derived controls: load a new index only from IDLE, release only
    // from GRANT, so ACK in IDLE has no effect.
    always_comb begin
        load_grant    = (state_q == IDLE) && (pend_q != 4'b0000);
        release_grant = (state_q == GRANT) && ACK;
    end

    // Grant index register, frozen for the whole grant (no preemption).
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            idx_q <= '0;
        end else if (load_grant) begin
            idx_q <= prio_idx;
        end
    end

    assign PEND  = pend_q;
    assign OVR   = ovr_q;
    assign IDX   = idx_q;
    assign VALID = (state_q == GRANT);
    assign E     = |pend_q;

endmodule

// File: doc/msi_request_capture.md
# msi_request_capture

Synchronous 4-channel request capture and grant stage that sits directly upstream of the team's 4-to-2 priority encoder and 2-to-4 demultiplexer. It synchronises four asynchronous request lines and detects their rising edges. Each event is latched in a pending register. The block presents one granted channel at a time as a 2-bit index, using the same priority order as the encoder, and holds it until the consumer acknowledges. Overrun on a channel that is already pending is reported as sticky status.

## Interface
Parameters:
- SYNC_STAGES, default 2: synchroniser depth per request line. Legal values are 2 or 3.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- REQ  in  4  asynchronous request lines, one per channel.
- MASK  in  4  channel enable, 1 = enabled. Used only when an event is captured.
- ACK  in  1  consumer acknowledge of the current grant.
- CLR  in  1  clears all OVR bits.
- PEND  out  4  pending-event register, one bit per channel.
- VALID  out  1  a grant is being presented on IDX.
- IDX  out  2  granted channel number. Valid only while VALID=1.
- E  out  1  any-pending flag, equal to |PEND (same meaning as the encoder's E).
- OVR  out  4  sticky overrun flags, one per channel.

## Operation
- Synchroniser: each REQ bit passes through a chain of SYNC_STAGES flops, then one history flop.
- Event detection: rise[i] = sync_out[i] & ~hist[i].
- Capture: a rise on an enabled channel (MASK[i]=1) sets PEND[i]. A rise on a masked channel is discarded and sets no flags.
- Masking: deasserting MASK does not clear a PEND bit that is already set.
- Overrun: a rise on an enabled channel whose PEND bit is already set, and is not being cleared in the same cycle, sets OVR[i]. The event is merged into the existing pending bit.
- OVR bits stay set until CLR=1. If CLR and a new overrun occur on the same edge, the set wins.
- Priority: channel 3 is highest and channel 0 lowest, matching the encoder.
- State machine, two states:
  - IDLE: VALID=0. If PEND≠0 at a clock edge, load IDX with the highest-priority pending channel, set VALID=1 and go to GRANT.
  - GRANT: VALID=1 and IDX is frozen. A higher-priority arrival does not preempt, and neither does masking the granted channel.
  - ACK=1 sampled in GRANT: clear PEND[IDX], drop VALID to 0 and return to IDLE.
- ACK while in IDLE is ignored.
- Same-edge collision: if ACK clears a channel on the same edge its new rise arrives, the set wins. PEND stays 1 and no overrun is recorded, because this is a new event.
- E is combinational from PEND. PEND, VALID, IDX and OVR are registered.

## Timing
- Reset (RST_N=0 at an edge): synchroniser, history, PEND, OVR, VALID and IDX all go to 0, E=0 and the state goes to IDLE.
- Reset mid-grant drops the grant and discards all pending events.
- A REQ line high at reset release is seen as a rising edge and is captured once the synchroniser fills.
- Capture latency: REQ high before edge k gives PEND set after edge k+SYNC_STAGES. With the default of 2, that is k+2.
- Grant latency: VALID=1 one edge after PEND becomes non-zero (edge k+3 with the default depth). IDX is valid in the same cycle as VALID.
- Release: ACK sampled at edge n clears VALID and PEND[IDX] after edge n.
- Re-grant: the earliest next VALID is after edge n+1. At least one VALID=0 cycle separates two grants.
- Throughput: at most one grant per 2 cycles.
- REQ pulses shorter than one CLK period may be missed. Levels held for at least 2 cycles are guaranteed to be captured.

## Test plan
- Reset and idle:
  - Stimulus: RST_N=0 for 2 cycles with REQ=0, then release.
  - Required: PEND=0, OVR=0, VALID=0, IDX=0, E=0 on every cycle.
- Single event latency:
  - Stimulus: MASK=4'b1111, REQ[1] rises before edge k, SYNC_STAGES=2.
  - Required: PEND=4'b0010 and E=1 after edge k+2; VALID=1 and IDX=2'b01 after edge k+3.
  - Then ACK for one cycle. Required: PEND=0 and VALID=0 on the next edge.
- Priority and no preemption:
  - Stimulus: REQ[0] and REQ[2] rise together. Required: IDX=2'b10 is granted first.
  - Stimulus: REQ[3] rises during that grant. Required: IDX stays 2'b10 until ACK.
  - Stimulus: ACK each grant as it appears. Required: grant order is 2'b11 then 2'b00, with one VALID=0 cycle between consecutive grants.
- Masking:
  - Stimulus: MASK=4'b1011 and REQ[2] rises. Required: PEND=0 and OVR=0.
  - Stimulus: set MASK[2]=1 while REQ[2] is still held high. Required: nothing is captured (no new edge).
- Overrun and CLR:
  - Stimulus: REQ[0] rises, falls, then rises again before any ACK. Required: OVR=4'b0001 and PEND[0]=1.
  - Stimulus: CLR pulse. Required: OVR=0.
  - Stimulus: CLR asserted on the same edge as a new overrun. Required: OVR[0] stays 1.
- Collision and reset mid-grant:
  - Stimulus: ACK channel 1 on the same edge as REQ[1]'s next rise reaches detection. Required: PEND[1] stays 1, OVR[1]=0, and channel 1 is re-granted.
  - Stimulus: RST_N=0 while VALID=1. Required: all outputs are 0 after that edge.
